// File: rtl/msx_ram_arbiter.sv
// ---------------------------------------------------------------------------
// msx_ram_arbiter
//
// Shares the single SDRAM/BRAM port of the MSX core between three requesters:
// CPU slot accesses, ROM/BIOS download writes and flash-emulation accesses.
// Arbitration happens only while idle, with fixed priority CPU > DL > FLASH.
// Every transaction runs IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
//
// Optional feature: define RAM_ARB_STARVE_EN to enable the flash starvation
// guard. After STARVE_MAX consecutive CPU/DL grants made while fl_req is high,
// the next grant goes to flash. With the macro undefined, strict priority is
// used and the counter does not exist.
//
// Ports
//   clk21m, reset          : single clock, synchronous active-high reset
//   cpu_req/addr/din/rnw/bram : CPU request strobe and payload (1-deep slot)
//   cpu_dout, cpu_ack      : CPU read data (held), one-cycle completion pulse
//   cpu_busy               : CPU request pending or in service (feeds WAIT)
//   dl_wr/addr/data        : download write strobe and payload (SDRAM only)
//   dl_wait                : download slot is full
//   fl_req/addr/din/rnw    : flash level request and payload (SDRAM only)
//   fl_dout, fl_ready      : flash read data, one-cycle completion pulse
//   ram_addr/din/rnw       : shared port address, write data, read/not-write
//   sdram_ce, bram_ce      : chip enables, high only in the ACCESS cycle
//   ram_dout               : shared port read data
// ---------------------------------------------------------------------------
module msx_ram_arbiter #(
  parameter int LAT_SDRAM  = 4,
  parameter int LAT_BRAM   = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [26:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rnw,
  input  logic        cpu_bram,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_busy,
  input  logic        dl_wr,
  input  logic [26:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        fl_req,
  input  logic [26:0] fl_addr,
  input  logic [7:0]  fl_din,
  input  logic        fl_rnw,
  output logic [7:0]  fl_dout,
  output logic        fl_ready,
  output logic [26:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_rnw,
  output logic        sdram_ce,
  output logic        bram_ce,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_CPU, G_DL, G_FL} grant_t;

  state_t      r_state;
  grant_t      r_grant;
  logic [3:0]  r_cnt;
  logic        r_bram;

  // CPU slot: r_cpu_busy covers both "pending" and "in service".
  logic        r_cpu_busy;
  logic [26:0] r_cpu_addr;
  logic [7:0]  r_cpu_din;
  logic        r_cpu_rnw;
  logic        r_cpu_bram;

  logic        r_dl_pend;
  logic [26:0] r_dl_addr;
  logic [7:0]  r_dl_data;

  logic        w_cpu_accept, w_dl_accept;
  logic        w_cpu_avail, w_dl_avail;
  logic        w_force_fl;
  logic        w_any;
  grant_t      w_win;
  logic [26:0] w_sel_addr;
  logic [7:0]  w_sel_din;
  logic        w_sel_rnw;
  logic        w_sel_bram;

  // A strobe arriving while its slot is occupied is dropped.
  assign w_cpu_accept = cpu_req & ~r_cpu_busy;
  assign w_dl_accept  = dl_wr & ~r_dl_pend;
  // A request strobed in the idle cycle is granted in that same cycle, which
  // gives the ACCESS-at-cycle-1 latency.
  assign w_cpu_avail  = r_cpu_busy | w_cpu_accept;
  assign w_dl_avail   = r_dl_pend | w_dl_accept;

  assign cpu_busy = r_cpu_busy;
  assign dl_wait  = r_dl_pend;

`ifdef RAM_ARB_STARVE_EN
  logic [3:0] r_starve;

  assign w_force_fl = fl_req && (r_starve == 4'(STARVE_MAX));

  always_ff @(posedge clk21m) begin
    if (reset || !fl_req) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      if (w_win == G_FL) r_starve <= '0;
      else               r_starve <= r_starve + 4'd1;
    end
  end
`else
  logic w_unused_starve;
  assign w_force_fl      = 1'b0;
  assign w_unused_starve = ^4'(STARVE_MAX);
`endif

  // Winner selection and payload mux for the idle-cycle grant.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_any      = 1'b1;
    w_win      = G_CPU;
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_rnw  = 1'b1;
    w_sel_bram = 1'b0;
    if (w_force_fl)       w_win = G_FL;
    else if (w_cpu_avail) w_win = G_CPU;
    else if (w_dl_avail)  w_win = G_DL;
    else if (fl_req)      w_win = G_FL;
    else                  w_any = 1'b0;

    unique case (w_win)
      G_CPU: begin
        w_sel_addr = r_cpu_busy ? r_cpu_addr : cpu_addr;
        w_sel_din  = r_cpu_busy ? r_cpu_din  : cpu_din;
        w_sel_rnw  = r_cpu_busy ? r_cpu_rnw  : cpu_rnw;
        w_sel_bram = r_cpu_busy ? r_cpu_bram : cpu_bram;
      end
      G_DL: begin
        w_sel_addr = r_dl_pend ? r_dl_addr : dl_addr;
        w_sel_din  = r_dl_pend ? r_dl_data : dl_data;
        w_sel_rnw  = 1'b0;
      end
      default: begin
        w_sel_addr = fl_addr;
        w_sel_din  = fl_din;
        w_sel_rnw  = fl_rnw;
      end
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk21m) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= G_CPU;
      r_cnt      <= '0;
      r_bram     <= 1'b0;
      r_cpu_busy <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_din  <= '0;
      r_cpu_rnw  <= 1'b1;
      r_cpu_bram <= 1'b0;
      r_dl_pend  <= 1'b0;
      r_dl_addr  <= '0;
      r_dl_data  <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_rnw    <= 1'b1;
      sdram_ce   <= 1'b0;
      bram_ce    <= 1'b0;
      cpu_dout   <= 8'hFF;
      fl_dout    <= 8'hFF;
      cpu_ack    <= 1'b0;
      fl_ready   <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      fl_ready <= 1'b0;

      if (w_cpu_accept) begin
        r_cpu_busy <= 1'b1;
        r_cpu_addr <= cpu_addr;
        r_cpu_din  <= cpu_din;
        r_cpu_rnw  <= cpu_rnw;
        r_cpu_bram <= cpu_bram;
      end
      if (w_dl_accept) begin
        r_dl_pend <= 1'b1;
        r_dl_addr <= dl_addr;
        r_dl_data <= dl_data;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_win;
            r_bram   <= w_sel_bram;
            ram_addr <= w_sel_addr;
            ram_din  <= w_sel_din;
            ram_rnw  <= w_sel_rnw;
            sdram_ce <= ~w_sel_bram;
            bram_ce  <= w_sel_bram;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          sdram_ce <= 1'b0;
          bram_ce  <= 1'b0;
          // Loaded with LAT-1: WAIT then lasts LAT cycles and its last cycle
          // is the one in which ram_dout is valid.
          r_cnt    <= r_bram ? 4'(LAT_BRAM - 1) : 4'(LAT_SDRAM - 1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            // Completion results are registered here so that ack, dout and
            // the cleared slot all become visible together in DONE.
            r_state <= S_DONE;
            unique case (r_grant)
              G_CPU: begin
                cpu_ack    <= 1'b1;
                r_cpu_busy <= 1'b0;
                if (ram_rnw) cpu_dout <= ram_dout;
              end
              G_DL: r_dl_pend <= 1'b0;
              default: begin
                fl_ready <= 1'b1;
                if (ram_rnw) fl_dout <= ram_dout;
              end
            endcase
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msx_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_msx_ram_arbiter
//
// Directed bench for msx_ram_arbiter with default parameters (LAT_SDRAM=4,
// LAT_BRAM=1, STARVE_MAX=8). "Cycle N" is the clock period following rising
// edge N of a scenario; inputs are driven and outputs sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_msx_ram_arbiter;

  logic        clk21m = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rnw, cpu_bram;
  logic [26:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack, cpu_busy;
  logic        dl_wr;
  logic [26:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        fl_req, fl_rnw;
  logic [26:0] fl_addr;
  logic [7:0]  fl_din, fl_dout;
  logic        fl_ready;
  logic [26:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_rnw, sdram_ce, bram_ce;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  msx_ram_arbiter dut (
    .clk21m   (clk21m),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_rnw  (cpu_rnw),
    .cpu_bram (cpu_bram),
    .cpu_dout (cpu_dout),
    .cpu_ack  (cpu_ack),
    .cpu_busy (cpu_busy),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .dl_wait  (dl_wait),
    .fl_req   (fl_req),
    .fl_addr  (fl_addr),
    .fl_din   (fl_din),
    .fl_rnw   (fl_rnw),
    .fl_dout  (fl_dout),
    .fl_ready (fl_ready),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_rnw  (ram_rnw),
    .sdram_ce (sdram_ce),
    .bram_ce  (bram_ce),
    .ram_dout (ram_dout)
  );

  always #5 clk21m = ~clk21m;

  task automatic tick();
    @(posedge clk21m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
    check({tag, " ram_din"},  32'(ram_din),  32'h0);
    check({tag, " ram_rnw"},  32'(ram_rnw),  32'h1);
    check({tag, " sdram_ce"}, 32'(sdram_ce), 32'h0);
    check({tag, " bram_ce"},  32'(bram_ce),  32'h0);
    check({tag, " cpu_dout"}, 32'(cpu_dout), 32'hFF);
    check({tag, " fl_dout"},  32'(fl_dout),  32'hFF);
    check({tag, " cpu_ack"},  32'(cpu_ack),  32'h0);
    check({tag, " fl_ready"}, 32'(fl_ready), 32'h0);
    check({tag, " cpu_busy"}, 32'(cpu_busy), 32'h0);
    check({tag, " dl_wait"},  32'(dl_wait),  32'h0);
  endtask

  initial begin
    int ce_cnt;
    int cpu_acks;
    int fl_acks;
    int fl_first;

    reset    = 1'b1;
    cpu_req  = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_rnw = 1'b1; cpu_bram = 1'b0;
    dl_wr    = 1'b0; dl_addr  = '0; dl_data = '0;
    fl_req   = 1'b0; fl_addr  = '0; fl_din  = '0; fl_rnw  = 1'b1;
    ram_dout = 8'h00;

    // Reset state
    repeat (3) tick();
    check_reset("por");
    reset = 1'b0;
    tick();

    // Single CPU SDRAM read: ce at 1, ack at 6, busy 1..5
    cpu_addr = 27'h0001234; cpu_rnw = 1'b1; cpu_bram = 1'b0;
    ram_dout = 8'h5A;
    cpu_req  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) cpu_req = 1'b0;
      check($sformatf("rd sdram_ce c%0d", c), 32'(sdram_ce), 32'(c == 1));
      check($sformatf("rd bram_ce c%0d", c),  32'(bram_ce),  32'h0);
      check($sformatf("rd cpu_ack c%0d", c),  32'(cpu_ack),  32'(c == 6));
      check($sformatf("rd cpu_busy c%0d", c), 32'(cpu_busy), 32'(c <= 5));
      if (c == 1) begin
        check("rd ram_addr", 32'(ram_addr), 32'h0001234);
        check("rd ram_rnw",  32'(ram_rnw),  32'h1);
      end
      if (c == 6) check("rd cpu_dout", 32'(cpu_dout), 32'h5A);
    end

    // BRAM write: bram_ce at 1, ack at 3, cpu_dout unchanged
    cpu_addr = 27'h0000042; cpu_rnw = 1'b0; cpu_bram = 1'b1; cpu_din = 8'h3C;
    ram_dout = 8'h99;
    cpu_req  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) cpu_req = 1'b0;
      check($sformatf("wr bram_ce c%0d", c),  32'(bram_ce),  32'(c == 1));
      check($sformatf("wr sdram_ce c%0d", c), 32'(sdram_ce), 32'h0);
      check($sformatf("wr cpu_ack c%0d", c),  32'(cpu_ack),  32'(c == 3));
      if (c == 1) begin
        check("wr ram_rnw",  32'(ram_rnw),  32'h0);
        check("wr ram_din",  32'(ram_din),  32'h3C);
        check("wr ram_addr", 32'(ram_addr), 32'h0000042);
      end
      if (c == 3) check("wr cpu_dout", 32'(cpu_dout), 32'h5A);
    end

    // Priority: CPU (write), DL, FLASH (read) all at cycle 0
    cpu_addr = 27'h0000100; cpu_rnw = 1'b0; cpu_bram = 1'b0; cpu_din = 8'h11;
    dl_addr  = 27'h0000200; dl_data = 8'h22;
    fl_addr  = 27'h0000300; fl_rnw  = 1'b1; fl_din = 8'h33;
    ram_dout = 8'hA5;
    cpu_req = 1'b1; dl_wr = 1'b1; fl_req = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 1) begin
        cpu_req = 1'b0;
        dl_wr   = 1'b0;
      end
      check($sformatf("pri cpu_ack c%0d", c),  32'(cpu_ack),  32'(c == 6));
      check($sformatf("pri fl_ready c%0d", c), 32'(fl_ready), 32'(c == 20));
      check($sformatf("pri dl_wait c%0d", c),  32'(dl_wait),  32'(c >= 1 && c <= 12));
      check($sformatf("pri sdram_ce c%0d", c), 32'(sdram_ce), 32'(c == 1 || c == 8 || c == 15));
      if (c == 1)  check("pri cpu addr", 32'(ram_addr), 32'h0000100);
      if (c == 8) begin
        check("pri dl addr", 32'(ram_addr), 32'h0000200);
        check("pri dl din",  32'(ram_din),  32'h22);
        check("pri dl rnw",  32'(ram_rnw),  32'h0);
      end
      if (c == 15) begin
        check("pri fl addr", 32'(ram_addr), 32'h0000300);
        check("pri fl rnw",  32'(ram_rnw),  32'h1);
      end
      if (c == 20) begin
        check("pri fl_dout",  32'(fl_dout),  32'hA5);
        check("pri cpu_dout", 32'(cpu_dout), 32'h5A);
        fl_req = 1'b0;
      end
    end

    // Download backpressure: second dl_wr on the next cycle is dropped
    dl_addr = 27'h0000ABC; dl_data = 8'h77;
    dl_wr   = 1'b1;
    ce_cnt  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        check("bp ram_addr", 32'(ram_addr), 32'h0000ABC);
        check("bp dl_wait",  32'(dl_wait),  32'h1);
        dl_addr = 27'h0000DEF;
        dl_data = 8'h88;
      end
      if (c == 2) dl_wr = 1'b0;
      ce_cnt += int'(sdram_ce);
    end
    check("bp ce count",    32'(ce_cnt),   32'd1);
    check("bp dl_wait end", 32'(dl_wait),  32'h0);
    check("bp addr held",   32'(ram_addr), 32'h0000ABC);

    // Starvation: fl_req held while CPU requests continuously for 79 cycles
    cpu_addr = 27'h0000555; cpu_rnw = 1'b1; cpu_bram = 1'b0;
    fl_addr  = 27'h0000666; fl_rnw  = 1'b1;
    cpu_req  = 1'b1; fl_req = 1'b1;
    cpu_acks = 0; fl_acks = 0; fl_first = -1;
    for (int c = 1; c <= 79; c++) begin
      tick();
      cpu_acks += int'(cpu_ack);
      if (fl_ready) begin
        fl_acks++;
        if (fl_first < 0) fl_first = c;
      end
    end
    cpu_req = 1'b0; fl_req = 1'b0;
`ifdef RAM_ARB_STARVE_EN
    check("starve cpu acks",  32'(cpu_acks), 32'd10);
    check("starve fl acks",   32'(fl_acks),  32'd1);
    check("starve fl cycle",  32'(fl_first), 32'd62);
`else
    check("starve cpu acks",  32'(cpu_acks), 32'd11);
    check("starve fl acks",   32'(fl_acks),  32'd0);
`endif
    repeat (10) tick();
    check("starve drain busy", 32'(cpu_busy), 32'h0);

    // Reset mid-WAIT: ACCESS at 1, reset asserted in cycle 3
    cpu_addr = 27'h0000777; cpu_rnw = 1'b1; cpu_bram = 1'b0;
    cpu_req  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        cpu_req = 1'b0;
        check("rst access ce", 32'(sdram_ce), 32'h1);
      end
      if (c == 3) reset = 1'b1;
      if (c == 4) begin
        check_reset("rst mid");
        reset = 1'b0;
      end
      if (c >= 4) check($sformatf("rst no ack c%0d", c), 32'(cpu_ack), 32'h0);
    end

    // Fresh request after the abandoned one completes normally
    ram_dout = 8'h3E;
    cpu_req  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) cpu_req = 1'b0;
      check($sformatf("post cpu_ack c%0d", c), 32'(cpu_ack), 32'(c == 6));
      if (c == 7) check("post cpu_dout", 32'(cpu_dout), 32'h3E);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
